// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller: 16-state FSM, IR, bypass and IDCODE data
// registers, and boundary-scan chain control strobes.
module jtag_tap_ctrl #(
  parameter int                  IR_WIDTH   = 4,
  parameter logic [31:0]         IDCODE_VAL = 32'h1000_0001,
  parameter logic [IR_WIDTH-1:0] IDCODE_OP  = IR_WIDTH'(4'b0001)
) (
  input  logic                tck,
  input  logic                trst_n,
  input  logic                tms,
  input  logic                tdi,
  input  logic                bsr_so,
  output logic                tdo,
  output logic                tdo_en,
  output logic [IR_WIDTH-1:0] instr,
  output logic                capture_dr,
  output logic                shift_dr,
  output logic                update_dr,
  output logic                sel_bsr,
  output logic [3:0]          tap_state
);

  typedef enum logic [3:0] {
    TLR    = 4'hF, RTI    = 4'hC,
    SEL_DR = 4'h7, CAP_DR = 4'h6, SH_DR = 4'h2, EX1_DR = 4'h1,
    PA_DR  = 4'h3, EX2_DR = 4'h0, UPD_DR = 4'h5,
    SEL_IR = 4'h4, CAP_IR = 4'hE, SH_IR = 4'hA, EX1_IR = 4'h9,
    PA_IR  = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD
  } tap_state_e;

  // IR capture pattern: two LSBs are 01 as required by 1149.1
  localparam logic [IR_WIDTH-1:0] IR_CAPT = IR_WIDTH'(2'b01);

  tap_state_e          state, nxt;
  logic [IR_WIDTH-1:0] ir_sr;
  logic                byp_r;
  logic [31:0]         id_r;
  logic                sel_byp, sel_id;
  logic                tdo_d;

  function automatic tap_state_e next_st(input tap_state_e s, input logic m);
    case (s)
      TLR:     return m ? TLR    : RTI;
      RTI:     return m ? SEL_DR : RTI;
      SEL_DR:  return m ? SEL_IR : CAP_DR;
      CAP_DR:  return m ? EX1_DR : SH_DR;
      SH_DR:   return m ? EX1_DR : SH_DR;
      EX1_DR:  return m ? UPD_DR : PA_DR;
      PA_DR:   return m ? EX2_DR : PA_DR;
      EX2_DR:  return m ? UPD_DR : SH_DR;
      UPD_DR:  return m ? SEL_DR : RTI;
      SEL_IR:  return m ? TLR    : CAP_IR;
      CAP_IR:  return m ? EX1_IR : SH_IR;
      SH_IR:   return m ? EX1_IR : SH_IR;
      EX1_IR:  return m ? UPD_IR : PA_IR;
      PA_IR:   return m ? EX2_IR : PA_IR;
      EX2_IR:  return m ? UPD_IR : SH_IR;
      UPD_IR:  return m ? SEL_DR : RTI;
      default: return TLR;
    endcase
  endfunction

  assign nxt       = next_st(state, tms);
  assign tap_state = state;

  // DR select decode from the active instruction
  assign sel_byp = &instr;
  assign sel_id  = (instr == IDCODE_OP) && !sel_byp;
  assign sel_bsr = !sel_byp && !sel_id;

  // Boundary-cell strobes are pure state decodes, only when the chain is selected
  assign capture_dr = sel_bsr && (state == CAP_DR);
  assign shift_dr   = sel_bsr && (state == SH_DR);
  assign update_dr  = sel_bsr && (state == UPD_DR);

  // TAP state register
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) state <= TLR;
    else         state <= nxt;
  end

  // IR shift/update; instr is forced to IDCODE both in TLR and on the edge
  // that enters TLR so it already reads IDCODE once TLR is reached.
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      ir_sr <= IR_CAPT;
      instr <= IDCODE_OP;
    end else begin
      case (state)
        CAP_IR:  ir_sr <= IR_CAPT;
        SH_IR:   ir_sr <= {tdi, ir_sr[IR_WIDTH-1:1]};
        default: ir_sr <= ir_sr;
      endcase
      if (state == TLR || nxt == TLR) instr <= IDCODE_OP;
      else if (state == UPD_IR)       instr <= ir_sr;
    end
  end

  // Bypass and IDCODE data registers; both hold outside capture/shift
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      byp_r <= 1'b0;
      id_r  <= IDCODE_VAL;
    end else if (state == CAP_DR) begin
      byp_r <= 1'b0;
      id_r  <= IDCODE_VAL;
    end else if (state == SH_DR) begin
      byp_r <= tdi;
      id_r  <= {tdi, id_r[31:1]};
    end
  end

  // Serial output mux for the current state
  always_comb begin
    tdo_d = 1'b0;
    case (state)
      SH_IR:   tdo_d = ir_sr[0];
      SH_DR:   tdo_d = sel_bsr ? bsr_so : (sel_byp ? byp_r : id_r[0]);
      default: tdo_d = 1'b0;
    endcase
  end

  // tdo/tdo_en launch on the falling edge
  always_ff @(negedge tck or negedge trst_n) begin
    if (!trst_n) begin
      tdo    <= 1'b0;
      tdo_en <= 1'b0;
    end else begin
      tdo    <= tdo_d;
      tdo_en <= (state == SH_IR) || (state == SH_DR);
    end
  end

endmodule

// File: doc/jtag_tap_ctrl.md
JTAG_TAP_CTRL -- requirements
Module: jtag_tap_ctrl

Interface
REQ-001 Parameters SHALL be: IR_WIDTH, default 4, instruction register width (2..8); IDCODE_VAL, default 32'h1000_0001, device ID (bit0 = 1); IDCODE_OP, default 4'b0001, IDCODE opcode.
REQ-002 Ports SHALL be:
- tck  in  1  test clock; all state updates on rising edge, tdo on falling edge.
- trst_n  in  1  asynchronous active-low reset.
- tms  in  1  mode select.
- tdi  in  1  serial data in.
- bsr_so  in  1  serial out of boundary-scan cell chain.
- tdo  out  1  serial data out.
- tdo_en  out  1  tdo output enable.
- instr  out  IR_WIDTH  active instruction.
- capture_dr  out  1  capture enable to boundary cells.
- shift_dr  out  1  shift select to boundary cells.
- update_dr  out  1  update strobe to boundary cells.
- sel_bsr  out  1  boundary chain selected as data register.
- tap_state  out  4  current FSM state, encoding per REQ-004.

Function
REQ-003 The controller SHALL implement the 16-state IEEE 1149.1 TAP FSM, advancing on each tck rising edge as a function of tms.
REQ-004 State encoding and transitions (tms=0 / tms=1) SHALL be:
- TLR 4'hF: RTI / TLR.
- RTI 4'hC: RTI / SEL_DR.
- SEL_DR 4'h7: CAP_DR / SEL_IR.
- CAP_DR 4'h6: SH_DR / EX1_DR.
- SH_DR 4'h2: SH_DR / EX1_DR.
- EX1_DR 4'h1: PA_DR / UPD_DR.
- PA_DR 4'h3: PA_DR / EX2_DR.
- EX2_DR 4'h0: SH_DR / UPD_DR.
- UPD_DR 4'h5: RTI / SEL_DR.
- SEL_IR 4'h4: CAP_IR / TLR.
- IR states mirror the DR states: CAP_IR 4'hE, SH_IR 4'hA, EX1_IR 4'h9, PA_IR 4'hB, EX2_IR 4'h8, UPD_IR 4'hD.
REQ-005 Five consecutive tms=1 edges SHALL reach TLR from any state.
REQ-006 capture_dr, shift_dr and update_dr SHALL be combinational decodes of the current state (CAP_DR, SH_DR, UPD_DR respectively), gated by sel_bsr.
REQ-007 IR shift register SHALL work as follows:
- In CAP_IR it loads {0...0,2'b01}.
- In SH_IR it shifts right with tdi entering the MSB.
- It holds in all other states.
REQ-008 instr SHALL load the IR shift register on the rising edge taken while in UPD_IR; it SHALL load IDCODE_OP on any edge taken while in TLR.
REQ-009 Data register selection SHALL be decoded from instr:
- All-ones: 1-bit bypass.
- IDCODE_OP: 32-bit ID register.
- Any other opcode: boundary chain, sel_bsr=1.
REQ-010 Bypass register SHALL load 0 in CAP_DR and load tdi in SH_DR.
REQ-011 ID register SHALL load IDCODE_VAL in CAP_DR and shift right with tdi into bit31 in SH_DR.
REQ-012 tdo SHALL be registered on the tck falling edge and driven as follows:
- In SH_IR: IR LSB.
- In SH_DR: LSB of the selected DR, or bsr_so when sel_bsr=1.
- Otherwise: 0.
REQ-013 tdo_en SHALL be registered on the falling edge: 1 while the state is SH_IR or SH_DR, else 0.
REQ-014 In PA_DR and PA_IR, all shift registers SHALL hold their contents; a later return to a shift state SHALL resume without data loss.

Reset
REQ-015 trst_n=0 SHALL, asynchronously:
- Force state to TLR.
- Set instr to IDCODE_OP and the IR shift register to {0...0,2'b01}.
- Clear the bypass register; load the ID register with IDCODE_VAL.
- Clear tdo and tdo_en.
REQ-016 Reset deassertion SHALL take effect at the next tck rising edge.
REQ-017 Reset asserted mid-shift SHALL discard partial shift data, and instr SHALL be IDCODE_OP after release.

Verification
REQ-018 Reset, then tms=0 for 1 edge, then tms 1,0,0 into SH_DR and shift 32 bits -> tdo sequence is IDCODE_VAL LSB-first (first bit 1).
REQ-019 Load IR 4'b1111 via SH_IR and UPD_IR, then enter SH_DR and shift tdi pattern 1,0,1,1 -> tdo is 0,1,0,1 (one-cycle bypass delay) with sel_bsr=0.
REQ-020 Load IR 4'b0010 -> sel_bsr=1; in CAP_DR, capture_dr=1; in SH_DR, shift_dr=1 and tdo follows bsr_so; in UPD_DR, update_dr=1 for exactly one tck.
REQ-021 From SH_IR, drive tms=1 for 5 edges -> tap_state 4'hF and instr=IDCODE_OP.
REQ-022 Assert trst_n low asynchronously while in SH_DR after shifting 10 bits -> tap_state 4'hF and tdo_en=0 immediately; after release, a fresh IDCODE read returns IDCODE_VAL.
REQ-023 Shift 16 ID bits, enter PA_DR for 3 edges, then pass through EX2_DR back to SH_DR and shift 16 more -> the concatenated 32 bits equal IDCODE_VAL.
